// File: rtl/fifo_uart_tx.sv
// Serial transmitter draining a byte FIFO: pops one byte per frame and sends start, DATA_W bits LSB-first, stop.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                rd_en_q;
  logic                baud_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx         = 1'b1;
    frame_done = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_enable && !fifo_empty) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = fifo_data;
        baud_d  = '0;
        bit_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        state_d = S_START;
      end
      S_START: begin
        tx     = 1'b0;
        baud_d = baud_end ? '0 : baud_q + BAUD_ONE;
        if (baud_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx     = shift_q[0];
        baud_d = baud_end ? '0 : baud_q + BAUD_ONE;
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_ONE;
          if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        tx     = parity_q;
        baud_d = baud_end ? '0 : baud_q + BAUD_ONE;
        if (baud_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        baud_d = baud_end ? '0 : baud_q + BAUD_ONE;
        if (baud_end) begin
          frame_done = 1'b1;
          // Second sampling point of tx_enable: chain straight into the next pop.
          state_d = (tx_enable && !fifo_empty) ? S_REQ : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rd_en_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      // The strobe is a flop that is high exactly for the REQ cycle.
      rd_en_q  <= (state_d == S_REQ);
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds bytes, a timeline model predicts every output cycle,
// and directed tests pin frame shape, gaps, pop counts, enable drop and async reset with literals.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FL = CPB * 11;
`else
  localparam int FL = CPB * 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en, tx, busy, frame_done;
  logic [2:0] dbg_state;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .tx(tx), .busy(busy),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] pend_byte = 8'h00;
  logic       pend = 1'b0;
  int         rd_empty_err = 0;

  always @(negedge clk) begin
    if (pend) begin
      fifo_data = pend_byte;
      pend = 1'b0;
    end
    if (fifo_rd_en) begin
      if (fifo_empty) rd_empty_err++;
      if (fifo_q.size() > 0) begin
        pend_byte = fifo_q.pop_front();
        pend = 1'b1;
        fifo_data = ~pend_byte;
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // ---------------- timeline model: {rd_en, tx, busy, frame_done} per cycle ----------------
  localparam logic [3:0] IDLE_V = 4'b0100;
  logic [3:0] exp_q[$];
  logic [3:0] drop_v;

  function automatic void push_frame(input logic [7:0] b);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0110);
    for (int i = 0; i < CPB; i++) exp_q.push_back(4'b0010);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < CPB; i++) exp_q.push_back({1'b0, b[j], 2'b10});
`ifdef FIFO_UART_TX_PARITY_EN
    for (int i = 0; i < CPB; i++) exp_q.push_back({1'b0, ^b, 2'b10});
`endif
    for (int i = 0; i < CPB - 1; i++) exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0111);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) drop_v = exp_q.pop_front();
      if (exp_q.size() == 0 && tx_enable && !fifo_empty)
        push_frame((fifo_q.size() > 0) ? fifo_q[0] : 8'h00);
    end
  end

  always @(negedge clk) begin
    chk("cycle_outputs", {28'd0, fifo_rd_en, tx, busy, frame_done},
        {28'd0, (exp_q.size() > 0) ? exp_q[0] : IDLE_V});
  end

  // ---------------- monitor logs ----------------
  int cyc = 0;
  bit tx_log [0:4095];
  int rd_cyc[$];
  int fd_cyc[$];
  int active_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (cyc < 4096) tx_log[cyc] = tx;
    if (fifo_rd_en) rd_cyc.push_back(cyc);
    if (frame_done) fd_cyc.push_back(cyc);
    if (busy || !tx || fifo_rd_en) active_cnt++;
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_rd(input int target, input int limit);
    int n = 0;
    while (rd_cyc.size() < target && n < limit) begin
      tick(1);
      n++;
    end
    chk("rd_wait", 32'(rd_cyc.size() >= target), 32'd1);
  endtask

  function automatic int start_of(input int j);
    return (j < rd_cyc.size()) ? rd_cyc[j] + 2 : 0;
  endfunction

  function automatic int fd_at(input int j);
    return (j < fd_cyc.size()) ? fd_cyc[j] : 0;
  endfunction

  function automatic bit log_at(input int c);
    return (c > 0 && c < 4096) ? tx_log[c] : 1'b0;
  endfunction

  // Start bit plus the 8 data bits, sampled one cycle into each bit period.
  function automatic logic [8:0] pat_at(input int s);
    logic [8:0] p;
    for (int i = 0; i < 9; i++) p[i] = log_at(s + CPB * i + 1);
    return p;
  endfunction

  // ---------------- directed tests ----------------
  int rb, fb, a0, s, r;
  logic [8:0] pats [0:2];

  initial begin
    pats[0] = 9'h000; pats[1] = 9'h1FE; pats[2] = 9'h078;

    tick(3);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // single byte 0xA5
    rb = rd_cyc.size(); fb = fd_cyc.size();
    tx_enable = 1'b1;
    fifo_q.push_back(8'hA5);
    tick(FL + 20);
    chk("a5_rd_pulses", 32'(rd_cyc.size() - rb), 32'd1);
    chk("a5_frames", 32'(fd_cyc.size() - fb), 32'd1);
    s = start_of(rb);
    chk("a5_load_high", 32'(log_at(s - 1)), 32'd1);
    chk("a5_pattern", 32'(pat_at(s)), 32'h14A);
    chk("a5_stop", 32'(log_at(s + FL - CPB + 1)), 32'd1);
    chk("a5_done_cycle", 32'(fd_at(fb) - s + 1), 32'(FL));
    chk("a5_idle_busy", 32'(busy), 32'd0);

    // three back-to-back bytes
    rb = rd_cyc.size(); fb = fd_cyc.size();
    fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF); fifo_q.push_back(8'h3C);
    tick(3 * (FL + 2) + 20);
    chk("b2b_rd_pulses", 32'(rd_cyc.size() - rb), 32'd3);
    chk("b2b_frames", 32'(fd_cyc.size() - fb), 32'd3);
    for (int j = 0; j < 3; j++)
      chk("b2b_pattern", 32'(pat_at(start_of(rb + j))), 32'(pats[j]));
    for (int j = 0; j < 2; j++) begin
      chk("b2b_spacing", 32'(fd_at(fb + j + 1) - fd_at(fb + j)), 32'(FL + 2));
      chk("b2b_gap", 32'({log_at(fd_at(fb + j) + 3), log_at(fd_at(fb + j) + 2),
                          log_at(fd_at(fb + j) + 1)}), 32'b011);
    end
    chk("rd_while_empty", 32'(rd_empty_err), 32'd0);
    chk("b2b_idle_busy", 32'(busy), 32'd0);

    // empty FIFO held
    rb = rd_cyc.size(); a0 = active_cnt;
    tick(100);
    chk("empty_active", 32'(active_cnt - a0), 32'd0);
    chk("empty_rd", 32'(rd_cyc.size() - rb), 32'd0);

    // enable dropped mid-frame with a second byte queued
    rb = rd_cyc.size(); fb = fd_cyc.size();
    fifo_q.push_back(8'h55); fifo_q.push_back(8'h11);
    wait_rd(rb + 1, 20);
    tick(8);
    tx_enable = 1'b0;
    tick(FL + 20);
    chk("drop_rd_pulses", 32'(rd_cyc.size() - rb), 32'd1);
    chk("drop_frames", 32'(fd_cyc.size() - fb), 32'd1);
    chk("drop_pattern", 32'(pat_at(start_of(rb))), 32'h0AA);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_left_in_fifo", 32'(fifo_q.size()), 32'd1);
    fifo_q.delete();
    tick(2);
    tx_enable = 1'b1;
    tick(2);

    // asynchronous reset during the 4th data bit of 0x07
    rb = rd_cyc.size();
    fifo_q.push_back(8'h07);
    wait_rd(rb + 1, 20);
    s = start_of(rb);
    r = s + CPB + 3 * CPB + 1;
    if (r > cyc) tick(r - cyc);
    chk("prereset_tx", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_tx", 32'(tx), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_rd_en", 32'(fifo_rd_en), 32'd0);
    tick(2);
    rst_n = 1'b1;
    rb = rd_cyc.size(); fb = fd_cyc.size(); a0 = active_cnt;
    tick(30);
    chk("post_reset_active", 32'(active_cnt - a0), 32'd0);
    chk("post_reset_rd", 32'(rd_cyc.size() - rb), 32'd0);

`ifdef FIFO_UART_TX_PARITY_EN
    rb = rd_cyc.size(); fb = fd_cyc.size();
    fifo_q.push_back(8'h07); fifo_q.push_back(8'h03);
    tick(2 * (FL + 2) + 20);
    chk("par_frames", 32'(fd_cyc.size() - fb), 32'd2);
    chk("par_len", 32'(fd_at(fb) - start_of(rb) + 1), 32'd44);
    chk("par_bits", 32'({log_at(start_of(rb + 1) + 9 * CPB + 1),
                         log_at(start_of(rb) + 9 * CPB + 1)}), 32'b01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
